// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
  typedef enum logic [1:0] {BOOT_WAIT, BOOT_WR, RUN} fetchState_e;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  localparam int DEFAULT_PC_STEP = 4;
endpackage

// File: rtl/pc_reg.sv
// Program counter: async reset to the reset vector; load beats increment.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    PC_STEP      = DEFAULT_PC_STEP,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] loadAddr,
  output logic [ADDR_WIDTH-1:0] pc
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  pc <= RESET_VECTOR;
    else if (load) pc <= loadAddr;
    else if (inc)  pc <= pc + ADDR_WIDTH'(PC_STEP);
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: copies the bios image into memory, then streams
// instructions from RESET_VECTOR with branch redirect and back-pressure.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    PC_STEP      = DEFAULT_PC_STEP,
  parameter int                    BOOT_WORDS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BOOT_BASE    = '0,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  boot_valid,
  input  logic [DATA_WIDTH-1:0] boot_word,
  output logic                  boot_ready,
  output logic                  booting,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);

  localparam int               CNT_W    = $clog2(BOOT_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BOOT_WORDS - 1);

  fetchState_e           state;
  logic [CNT_W-1:0]      bootCnt;
  logic [ADDR_WIDTH-1:0] bootAddr;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] wbuf;
  logic                  inRun, inBootWr, redirect, runReq, fetchDone;

  assign inRun     = (state == RUN);
  assign inBootWr  = (state == BOOT_WR);
  assign redirect  = inRun && branch_taken;
  // A branch withdraws any pending read, so a coincident ack is dropped.
  assign runReq    = inRun && !branch_taken && (!instr_valid || instr_ready);
  assign fetchDone = runReq && mem_ack;

  assign boot_ready = (state == BOOT_WAIT) && reset_n;
  assign booting    = !inRun;
  assign mem_req    = inBootWr || runReq;
  assign mem_we     = inBootWr ? MEM_WR : MEM_RD;
  assign mem_addr   = inBootWr ? bootAddr : (inRun ? pc : '0);
  assign mem_wdata  = inBootWr ? wbuf : '0;

  pc_reg #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PC_STEP     (PC_STEP),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (redirect),
    .inc     (fetchDone),
    .loadAddr(branch_target),
    .pc      (pc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT_WAIT;
      bootCnt     <= '0;
      bootAddr    <= BOOT_BASE;
      wbuf        <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      case (state)
        BOOT_WAIT: if (boot_valid) begin
          wbuf  <= boot_word;
          state <= BOOT_WR;
        end
        BOOT_WR: if (mem_ack) begin
          bootAddr <= bootAddr + ADDR_WIDTH'(PC_STEP);
          bootCnt  <= bootCnt + 1'b1;
          state    <= (bootCnt == LAST_CNT) ? RUN : BOOT_WAIT;
        end
        RUN: begin
          if (branch_taken) begin
            instr_valid <= 1'b0;
          end else if (fetchDone) begin
            instr       <= mem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
          end
        end
        default: state <= BOOT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a wait-state memory model.
module tb_fetch_unit;
  logic        clock, reset_n;
  logic        boot_valid, boot_ready, booting;
  logic [31:0] boot_word;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;

  int          tests = 0, fails = 0;
  logic [3:0]  waitStates = 4'd0, waitCnt = 4'd0;
  logic        forceAck = 1'b0;
  logic [31:0] rdBase = 32'd0;

  fetch_unit #(.BOOT_WORDS(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .boot_valid(boot_valid), .boot_word(boot_word), .boot_ready(boot_ready), .booting(booting),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory: word at byte address a reads as a[9:2] + rdBase; ack after waitStates cycles.
  assign mem_rdata = 32'(mem_addr[9:2]) + rdBase;
  assign mem_ack   = forceAck || (mem_req && (waitCnt == waitStates));

  always @(posedge clock) begin
    if (!mem_req || mem_ack) waitCnt <= 4'd0;
    else                     waitCnt <= waitCnt + 4'd1;
  end

  task automatic test_reset;
    reset_n = 1'b0; boot_valid = 1'b0; boot_word = '0; branch_taken = 1'b0;
    branch_target = '0; instr_ready = 1'b0;
    #1;
    tests++; if (booting !== 1'b1) begin fails++; $display("FAIL rst_booting got %b exp 1", booting); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", mem_req); end
    tests++; if (boot_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", boot_ready); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_ivalid got %b exp 0", instr_valid); end
    tests++; if ({mem_we, mem_addr, mem_wdata, instr, instr_pc} !== '0) begin fails++; $display("FAIL rst_outs nonzero addr %h instr %h", mem_addr, instr); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    tests++; if (boot_ready !== 1'b1) begin fails++; $display("FAIL rst_rel_ready got %b exp 1", boot_ready); end
  endtask

  // Four zero-wait boot words; branch_taken held high to show it is ignored.
  task automatic test_boot;
    waitStates = 4'd0; forceAck = 1'b0; instr_ready = 1'b1; rdBase = 32'd0;
    branch_taken = 1'b1; branch_target = 32'h200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); boot_valid = 1'b1; boot_word = 32'hA0 + 32'(i); #1;
      tests++; if ({boot_ready, booting, mem_req} !== 3'b110) begin fails++; $display("FAIL boot_wait%0d rdy/boot/req got %b exp 110", i, {boot_ready, booting, mem_req}); end
      @(negedge clock); boot_valid = 1'b0; #1;
      tests++; if ({mem_req, mem_we, booting, boot_ready} !== 4'b1110) begin fails++; $display("FAIL boot_wr%0d req/we/boot/rdy got %b exp 1110", i, {mem_req, mem_we, booting, boot_ready}); end
      tests++; if (mem_addr !== 32'(4 * i)) begin fails++; $display("FAIL boot_addr%0d got %h exp %h", i, mem_addr, 4 * i); end
      tests++; if (mem_wdata !== 32'hA0 + 32'(i)) begin fails++; $display("FAIL boot_data%0d got %h exp %h", i, mem_wdata, 32'hA0 + 32'(i)); end
    end
    @(negedge clock); branch_taken = 1'b0; #1;
    tests++; if (booting !== 1'b0) begin fails++; $display("FAIL boot_done booting got %b exp 0", booting); end
    tests++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h0) begin fails++; $display("FAIL first_fetch req/we %b addr %h exp 10/0", {mem_req, mem_we}, mem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL boot_ivalid got %b exp 0", instr_valid); end
  endtask

  task automatic test_run;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); #1;
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr !== 32'(k)) begin
        fails++; $display("FAIL run%0d v/pc/instr got %b/%h/%h exp 1/%h/%h", k, instr_valid, instr_pc, instr, 4 * k, k);
      end
    end
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin fails++; $display("FAIL run_next req/addr got %b/%h exp 1/10", mem_req, mem_addr); end
  endtask

  // Three wait states: each address held 4 cycles, one delivery per 4 cycles.
  task automatic test_wait_states;
    waitStates = 4'd3;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clock); #1;
      tests++; if (mem_req !== 1'b1 || mem_addr !== 32'(16 + 4 * (t / 4))) begin
        fails++; $display("FAIL ws_addr t%0d req/addr got %b/%h exp 1/%h", t, mem_req, mem_addr, 16 + 4 * (t / 4));
      end
      if (t % 4 == 0) begin
        tests++; if (instr_valid !== 1'b1 || instr !== 32'(3 + t / 4) || instr_pc !== 32'(12 + t)) begin
          fails++; $display("FAIL ws_deliver t%0d v/instr/pc got %b/%h/%h exp 1/%h/%h", t, instr_valid, instr, instr_pc, 3 + t / 4, 12 + t);
        end
      end else begin
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL ws_idle t%0d valid got %b exp 0", t, instr_valid); end
      end
    end
  endtask

  task automatic test_backpressure;
    @(negedge clock); branch_taken = 1'b1; branch_target = 32'h8; waitStates = 4'd0; rdBase = 32'h0F; #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL bp_branch_req got %b exp 0", mem_req); end
    @(negedge clock); branch_taken = 1'b0; instr_ready = 1'b0; #1;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin fails++; $display("FAIL bp_fetch8 req/addr got %b/%h exp 1/8", mem_req, mem_addr); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); #1;
      tests++; if ({instr_valid, mem_req} !== 2'b10 || instr !== 32'h11 || instr_pc !== 32'h8 || mem_addr !== 32'hC) begin
        fails++; $display("FAIL bp_hold%0d v/req/instr/pc/addr got %b/%b/%h/%h/%h exp 1/0/11/8/c", c, instr_valid, mem_req, instr, instr_pc, mem_addr);
      end
    end
    @(negedge clock); instr_ready = 1'b1; #1;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'hC) begin fails++; $display("FAIL bp_resume req/addr got %b/%h exp 1/c", mem_req, mem_addr); end
    @(negedge clock); #1;
    tests++; if (instr_valid !== 1'b1 || instr !== 32'h12 || instr_pc !== 32'hC) begin fails++; $display("FAIL bp_after v/instr/pc got %b/%h/%h exp 1/12/c", instr_valid, instr, instr_pc); end
  endtask

  task automatic test_branch;
    @(negedge clock); branch_taken = 1'b1; branch_target = 32'h14; waitStates = 4'd2; #1;
    @(negedge clock); branch_taken = 1'b0; #1;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h14 || instr_valid !== 1'b0) begin fails++; $display("FAIL br_to14 req/addr/v got %b/%h/%b exp 1/14/0", mem_req, mem_addr, instr_valid); end
    @(negedge clock); #1;
    @(negedge clock); branch_taken = 1'b1; branch_target = 32'h100; forceAck = 1'b1; #1;
    tests++; if (mem_req !== 1'b0 || mem_ack !== 1'b1) begin fails++; $display("FAIL br_coincide req/ack got %b/%b exp 0/1", mem_req, mem_ack); end
    @(negedge clock); branch_taken = 1'b0; forceAck = 1'b0; waitStates = 4'd0; #1;
    tests++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin fails++; $display("FAIL br_target v/req/addr got %b/%b/%h exp 0/1/100", instr_valid, mem_req, mem_addr); end
    @(negedge clock); #1;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h4F) begin fails++; $display("FAIL br_instr v/pc/instr got %b/%h/%h exp 1/100/4f", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_wrap;
    @(negedge clock); branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; #1;
    @(negedge clock); branch_taken = 1'b0; #1;
    tests++; if (mem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr got %h exp fffffffc", mem_addr); end
    @(negedge clock); #1;
    tests++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'h10E || mem_addr !== 32'h0) begin fails++; $display("FAIL wrap_next pc/instr/addr got %h/%h/%h exp fffffffc/10e/0", instr_pc, instr, mem_addr); end
  endtask

  task automatic test_reset_mid_boot;
    @(negedge clock); reset_n = 1'b0; #1;
    tests++; if (booting !== 1'b1 || instr_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL rb_reset boot/v/req got %b/%b/%b exp 1/0/0", booting, instr_valid, mem_req); end
    @(negedge clock); reset_n = 1'b1; waitStates = 4'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); boot_valid = 1'b1; boot_word = 32'hB0 + 32'(i);
      @(negedge clock); boot_valid = 1'b0;
    end
    @(negedge clock); boot_valid = 1'b1; boot_word = 32'hB2; waitStates = 4'd2;
    @(negedge clock); boot_valid = 1'b0; #1;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || mem_wdata !== 32'hB2) begin fails++; $display("FAIL rb_third req/addr/data got %b/%h/%h exp 1/8/b2", mem_req, mem_addr, mem_wdata); end
    @(negedge clock); #2 reset_n = 1'b0; #1;
    tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || booting !== 1'b1) begin fails++; $display("FAIL rb_abort req/we/boot got %b/%b/%b exp 0/0/1", mem_req, mem_we, booting); end
    @(negedge clock); reset_n = 1'b1;
    test_boot();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_boot();
    test_run();
    test_wait_states();
    test_backpressure();
    test_branch();
    test_wrap();
    test_reset_mid_boot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end that replaces the ad-hoc PC/adder/mux/bios wiring in the top level.
- Phase 1 (boot): copies BOOT_WORDS words streamed from the bios into memory, starting at BOOT_BASE.
- Phase 2 (run): fetches instructions from RESET_VECTOR onward through a req/ack memory port.
- Run phase supports taken-branch redirect, downstream back-pressure and wait-state memory.

Parameters:
- ADDR_WIDTH, 32, memory address width; PC width.
- DATA_WIDTH, 32, instruction/memory word width.
- PC_STEP, 4, byte increment per sequential fetch and per boot write.
- BOOT_WORDS, 16, number of bios words copied before fetch starts. Must be at least 1.
- BOOT_BASE, 0, first memory address written during boot.
- RESET_VECTOR, 0, first fetch address after boot.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- boot_valid  in  1  bios presents a word on boot_word.
- boot_word  in  DATA_WIDTH  bios data word.
- boot_ready  out  1  unit accepts boot_word this cycle.
- booting  out  1  high while in the boot phase.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (boot), 0 = read (fetch).
- mem_addr  out  ADDR_WIDTH  access address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_ack  in  1  memory completes the access this cycle; same-cycle ack is allowed.
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack is high and mem_we is 0.
- branch_taken  in  1  redirect request (one-cycle pulse).
- branch_target  in  ADDR_WIDTH  redirect address.
- instr_valid  out  1  instr and instr_pc are valid.
- instr  out  DATA_WIDTH  fetched instruction.
- instr_pc  out  ADDR_WIDTH  address of instr.
- instr_ready  in  1  downstream consumes instr this cycle.

Behaviour:
- Reset values: state=BOOT_WAIT, boot_cnt=0, boot_addr=BOOT_BASE, pc=RESET_VECTOR, wbuf=0, instr_valid=0, instr=0, instr_pc=0. All outputs are driven low except booting=1.
- Reset is asynchronous. Assertion mid-access aborts immediately: mem_req drops with no further handshake, and boot restarts from word 0.
- State BOOT_WAIT:
  - boot_ready=1, mem_req=0.
  - When boot_valid is high, capture boot_word into wbuf and go to BOOT_WR.
- State BOOT_WR:
  - boot_ready=0, mem_req=1, mem_we=1, mem_addr=boot_addr, mem_wdata=wbuf. These are held stable until mem_ack.
  - On mem_ack: boot_addr += PC_STEP and boot_cnt += 1. If boot_cnt was BOOT_WORDS-1, go to RUN; otherwise go to BOOT_WAIT.
- Boot phase rules:
  - branch_taken and instr_ready are ignored.
  - instr_valid stays 0.
  - booting=1 in BOOT_WAIT and BOOT_WR; booting=0 in RUN.
- State RUN (terminal until reset):
  - mem_we=0, mem_addr=pc, mem_req = !branch_taken && (!instr_valid || instr_ready).
  - Output side: instr_ready with instr_valid consumes the current word.
  - On mem_ack with mem_req: instr<=mem_rdata, instr_pc<=pc, pc<=pc+PC_STEP, instr_valid<=1.
  - Consume without a new ack clears instr_valid.
  - Throughput: one instruction per cycle with a zero-wait memory.
  - Memory wait states: mem_req and mem_addr are held until mem_ack, provided no branch arrives and the output slot stays available.
- Branch (RUN only), highest priority:
  - pc<=branch_target and instr_valid<=0 (flush).
  - mem_req is forced low that cycle, so any in-flight request is abandoned and a coincident mem_ack is ignored.
  - The fetch from the target starts on the next cycle.
  - If branch_taken and instr_ready coincide, the flush wins and the word is considered consumed.
- Back-pressure: while instr_valid=1 and instr_ready=0, mem_req=0, pc is unchanged and outputs are held.
- Arithmetic:
  - pc and boot_addr are ADDR_WIDTH-wide modulo adders, so 0xFFFFFFFC+4 wraps to 0.
  - boot_cnt width is clog2(BOOT_WORDS+1).
- Memory contract: mem_ack is only honoured in cycles with mem_req=1, and the memory tolerates request withdrawal.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (BOOT_WAIT, BOOT_WR, RUN);
  - the mem_we encodings (MEM_RD=0, MEM_WR=1);
  - the default PC_STEP.
- Sub-module pc_reg: ADDR_WIDTH register with async active-low reset to RESET_VECTOR, load (branch) and increment (PC_STEP) controls, with load having priority. It is reused later by the decode-stage PC.

Test Plan:
- BOOT_WORDS=4: bios sends 0xA0..0xA3 with zero-wait ack -> writes appear at 0x0, 0x4, 0x8, 0xC with matching data; booting falls after the 4th ack; first read is at 0x0.
- Run with instr_ready=1 and memory holding mem[i]=i at byte address 4i -> instr_valid high every cycle; instr_pc sequence is 0, 4, 8, 12; instr sequence is 0, 1, 2, 3.
- Memory with 3 wait states -> mem_addr stays stable for 4 cycles per fetch; one instruction is delivered every 4 cycles; no duplicates and no skips.
- instr_ready low for 5 cycles while instr=0x11 at pc 0x8 -> outputs hold at 0x11/0x8, mem_req=0, and the fetch at 0xC resumes the cycle after instr_ready rises.
- branch_taken to 0x100 during a waiting fetch at 0x14 while mem_ack arrives in the same cycle -> ack ignored; the next fetch address is 0x100; the next instr_pc is 0x100.
- reset_n pulsed low in the middle of the 3rd boot write -> mem_req drops immediately; after release, boot restarts at BOOT_BASE with boot_cnt=0.
